// File: rtl/audio_pkg.sv
// Shared types and helpers for the codec audio datapath (DAC transmit and ADC receive).
package audio_pkg;

  localparam int unsigned AUDIO_WIDTH = 16;

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_SHIFT, S_PAD} tx_state_e;
  typedef enum logic {CH_LEFT, CH_RIGHT} chan_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/lrck_edge.sv
// Registers the codec LRCK and flags the cycle on which it changes level.
// A fall marks a left-channel start, a rise a right-channel start.
module lrck_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_lrck,
  output logic o_left_start,
  output logic o_right_start
);

  logic lrck_d, lrck_q;

  always_comb lrck_d = i_lrck;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) lrck_q <= 1'b0;
    else          lrck_q <= lrck_d;
  end

  assign o_left_start  = lrck_q & ~i_lrck;
  assign o_right_start = ~lrck_q & i_lrck;

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S playback transmitter: one-frame holding register, LRCK-framed MSB-first serializer,
// frame-start pulse for the fetch pointer and a saturating underrun counter.
module i2s_dac_tx
  import audio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = AUDIO_WIDTH,
  parameter int unsigned I2S_DELAY       = 1,
  parameter int unsigned UNDERRUN_REPEAT = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_daclrck,
  input  logic [DATA_WIDTH-1:0] i_sample_l,
  input  logic [DATA_WIDTH-1:0] i_sample_r,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_dacdat,
  output logic                  o_frame_start,
  output logic                  o_underrun,
  output logic [15:0]           o_underrun_cnt
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

  logic left_start, right_start, transfer;

  tx_state_e             state_d, state_q;
  logic [DATA_WIDTH-1:0] hold_l_d, hold_l_q, hold_r_d, hold_r_q;
  logic                  hold_full_d, hold_full_q;
  logic [DATA_WIDTH-1:0] active_l_d, active_l_q, active_r_d, active_r_q;
  logic [DATA_WIDTH-1:0] shift_d, shift_q;
  logic [CntW-1:0]       bit_cnt_d, bit_cnt_q;
  logic                  dacdat_d, dacdat_q;
  logic                  frame_start_d, frame_start_q;
  logic                  underrun_d, underrun_q;
  logic [15:0]           underrun_cnt_d, underrun_cnt_q;
  chan_e                 start_ch;
  logic [DATA_WIDTH-1:0] start_data;

  lrck_edge u_lrck_edge (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_lrck        (i_daclrck),
    .o_left_start  (left_start),
    .o_right_start (right_start)
  );

  assign o_ready  = i_en && !hold_full_q;
  assign transfer = i_valid && o_ready;

  always_comb begin
    state_d        = state_q;
    hold_l_d       = hold_l_q;
    hold_r_d       = hold_r_q;
    hold_full_d    = hold_full_q;
    active_l_d     = active_l_q;
    active_r_d     = active_r_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    dacdat_d       = dacdat_q;
    frame_start_d  = 1'b0;
    underrun_d     = 1'b0;
    underrun_cnt_d = underrun_cnt_q;
    start_ch       = left_start ? CH_LEFT : CH_RIGHT;
    start_data     = '0;

    if (!i_en) begin
      state_d     = S_IDLE;
      dacdat_d    = 1'b0;
      hold_full_d = 1'b0;
      bit_cnt_d   = '0;
    end else begin
      if (left_start) begin
        if (hold_full_q) begin
          active_l_d    = hold_l_q;
          active_r_d    = hold_r_q;
          hold_full_d   = 1'b0;
          frame_start_d = 1'b1;
        end else begin
          underrun_d     = 1'b1;
          underrun_cnt_d = sat_inc16(underrun_cnt_q);
          if (UNDERRUN_REPEAT == 0) begin
            active_l_d = '0;
            active_r_d = '0;
          end
        end
      end
      // A frame arriving on the left-start cycle lands in the holding register, never on air.
      if (transfer) begin
        hold_l_d    = i_sample_l;
        hold_r_d    = i_sample_r;
        hold_full_d = 1'b1;
      end

      // Any edge restarts the serializer, aborting a channel still in progress.
      if (left_start || (right_start && state_q != S_IDLE)) begin
        start_data = (start_ch == CH_LEFT) ? active_l_d : active_r_q;
        if (I2S_DELAY != 0) begin
          state_d   = S_DELAY;
          dacdat_d  = 1'b0;
          shift_d   = start_data;
          bit_cnt_d = '0;
        end else begin
          state_d   = S_SHIFT;
          dacdat_d  = start_data[DATA_WIDTH-1];
          shift_d   = start_data << 1;
          bit_cnt_d = CntW'(1);
        end
      end else begin
        unique case (state_q)
          S_IDLE: dacdat_d = 1'b0;
          S_DELAY, S_SHIFT: begin
            if (bit_cnt_q == CntW'(DATA_WIDTH)) begin
              state_d  = S_PAD;
              dacdat_d = 1'b0;
            end else begin
              state_d   = S_SHIFT;
              dacdat_d  = shift_q[DATA_WIDTH-1];
              shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
              bit_cnt_d = bit_cnt_q + CntW'(1);
            end
          end
          S_PAD:   dacdat_d = 1'b0;
          default: begin
            state_d  = S_IDLE;
            dacdat_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= S_IDLE;
      hold_l_q       <= '0;
      hold_r_q       <= '0;
      hold_full_q    <= 1'b0;
      active_l_q     <= '0;
      active_r_q     <= '0;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      dacdat_q       <= 1'b0;
      frame_start_q  <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      hold_l_q       <= hold_l_d;
      hold_r_q       <= hold_r_d;
      hold_full_q    <= hold_full_d;
      active_l_q     <= active_l_d;
      active_r_q     <= active_r_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      dacdat_q       <= dacdat_d;
      frame_start_q  <= frame_start_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign o_dacdat       = dacdat_q;
  assign o_frame_start  = frame_start_q;
  assign o_underrun     = underrun_q;
  assign o_underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: a zero-fill instance and a repeat-last-frame instance share
// all inputs; each task drives one scenario and checks both serial streams.
module tb_i2s_dac_tx;

  logic        clk = 1'b0;
  logic        rst_n, en, lrck, valid;
  logic [15:0] sl, sr;

  logic        ready, dacdat, fs, ur;
  logic [15:0] cnt;
  logic        ready_r, dacdat_r, fs_r, ur_r;
  logic [15:0] cnt_r;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  i2s_dac_tx #(.DATA_WIDTH(16), .I2S_DELAY(1), .UNDERRUN_REPEAT(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_daclrck(lrck),
    .i_sample_l(sl), .i_sample_r(sr), .i_valid(valid), .o_ready(ready),
    .o_dacdat(dacdat), .o_frame_start(fs), .o_underrun(ur), .o_underrun_cnt(cnt)
  );

  i2s_dac_tx #(.DATA_WIDTH(16), .I2S_DELAY(1), .UNDERRUN_REPEAT(1)) dut_rep (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_daclrck(lrck),
    .i_sample_l(sl), .i_sample_r(sr), .i_valid(valid), .o_ready(ready_r),
    .o_dacdat(dacdat_r), .o_frame_start(fs_r), .o_underrun(ur_r), .o_underrun_cnt(cnt_r)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Holds LRCK at lvl for n cycles; cycle 0 is the delay slot, cycles 1..16 the data bits.
  task automatic chan(input logic lvl, input int n, output logic [15:0] got,
                      output logic [15:0] got_r, output logic first, output logic pad_nz,
                      output int fs_cnt, output logic fs_first, output int ur_cnt,
                      output int skew);
    got = '0; got_r = '0; first = 1'b0; pad_nz = 1'b0;
    fs_cnt = 0; fs_first = 1'b0; ur_cnt = 0; skew = 0;
    lrck = lvl;
    for (int i = 0; i < n; i++) begin
      step;
      if (i == 0) begin
        first    = dacdat | dacdat_r;
        fs_first = fs;
      end else if (i <= 16) begin
        got   = {got[14:0], dacdat};
        got_r = {got_r[14:0], dacdat_r};
      end else begin
        pad_nz = pad_nz | dacdat | dacdat_r;
      end
      fs_cnt += int'(fs);
      ur_cnt += int'(ur);
      if (fs !== fs_r || ur !== ur_r) skew++;
    end
  endtask

  task automatic offer(input logic [15:0] l, input logic [15:0] r);
    int w;
    sl = l; sr = r; valid = 1'b1; w = 0;
    while (!ready && w < 50) begin
      step;
      w++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL offer_ready: o_ready=%b after %0d cycles, want 1", ready, w);
    end
    step;
    valid = 1'b0;
  endtask

  logic [15:0] g, gr;
  logic        f0, pz, fs0;
  int          nfs, nur, sk;

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; lrck = 1'b1; valid = 1'b0; sl = '0; sr = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dacdat, fs, ur, cnt, ready, ready_r} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: dacdat=%b fs=%b ur=%b cnt=%h ready=%b, want all 0",
               dacdat, fs, ur, cnt, ready);
    end
    rst_n = 1'b1;
    step; step;
    en = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1 || dacdat !== 1'b0) begin
      errors++;
      $display("FAIL enable_ready: ready=%b dacdat=%b, want 1/0", ready, dacdat);
    end
  endtask

  task automatic test_basic_frame;
    offer(16'hA5A5, 16'h3C3C);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_full_ready: ready=%b, want 0", ready);
    end
    chan(1'b0, 32, g, gr, f0, pz, nfs, fs0, nur, sk);
    checks++;
    if ({f0, g, gr, pz} !== {1'b0, 16'hA5A5, 16'hA5A5, 1'b0}) begin
      errors++;
      $display("FAIL basic_left: delay=%b bits=%h/%h pad=%b, want 0 a5a5/a5a5 0", f0, g, gr, pz);
    end
    checks++;
    if (fs0 !== 1'b1 || nfs != 1 || nur != 0) begin
      errors++;
      $display("FAIL basic_frame_start: first=%b pulses=%0d ur=%0d, want 1 1 0", fs0, nfs, nur);
    end
    chan(1'b1, 32, g, gr, f0, pz, nfs, fs0, nur, sk);
    checks++;
    if ({f0, g, gr, pz} !== {1'b0, 16'h3C3C, 16'h3C3C, 1'b0} || nfs != 0) begin
      errors++;
      $display("FAIL basic_right: delay=%b bits=%h/%h pad=%b fs=%0d, want 0 3c3c/3c3c 0 0",
               f0, g, gr, pz, nfs);
    end
  endtask

  task automatic test_underrun;
    chan(1'b0, 32, g, gr, f0, pz, nfs, fs0, nur, sk);
    checks++;
    if (nur != 1 || nfs != 0 || sk != 0) begin
      errors++;
      $display("FAIL underrun_pulse: ur=%0d fs=%0d skew=%0d, want 1 0 0", nur, nfs, sk);
    end
    checks++;
    if ({g, gr, pz} !== {16'h0000, 16'hA5A5, 1'b0}) begin
      errors++;
      $display("FAIL underrun_left: zero=%h repeat=%h pad=%b, want 0000 a5a5 0", g, gr, pz);
    end
    chan(1'b1, 32, g, gr, f0, pz, nfs, fs0, nur, sk);
    checks++;
    if ({g, gr} !== {16'h0000, 16'h3C3C} || cnt !== 16'd1 || cnt_r !== 16'd1) begin
      errors++;
      $display("FAIL underrun_right: zero=%h repeat=%h cnt=%0d/%0d, want 0000 3c3c 1/1",
               g, gr, cnt, cnt_r);
    end
  endtask

  task automatic test_back_to_back;
    offer(16'h1111, 16'h2222);
    sl = 16'h3333; sr = 16'h4444; valid = 1'b1;
    chan(1'b0, 32, g, gr, f0, pz, nfs, fs0, nur, sk);
    valid = 1'b0;
    checks++;
    if (g !== 16'h1111 || fs0 !== 1'b1 || nur != 0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_left: bits=%h fs=%b ur=%0d ready=%b, want 1111 1 0 0", g, fs0, nur, ready);
    end
    chan(1'b1, 32, g, gr, f0, pz, nfs, fs0, nur, sk);
    checks++;
    if (g !== 16'h2222) begin
      errors++;
      $display("FAIL b2b_right: bits=%h, want 2222", g);
    end
    chan(1'b0, 32, g, gr, f0, pz, nfs, fs0, nur, sk);
    checks++;
    if (g !== 16'h3333 || nfs != 1 || nur != 0) begin
      errors++;
      $display("FAIL b2b_next_left: bits=%h fs=%0d ur=%0d, want 3333 1 0", g, nfs, nur);
    end
    chan(1'b1, 32, g, gr, f0, pz, nfs, fs0, nur, sk);
    checks++;
    if (g !== 16'h4444) begin
      errors++;
      $display("FAIL b2b_next_right: bits=%h, want 4444", g);
    end
    // Frame offered on the very cycle of an empty-hold left start: stored but not played.
    sl = 16'h5555; sr = 16'h6666; valid = 1'b1;
    chan(1'b0, 32, g, gr, f0, pz, nfs, fs0, nur, sk);
    valid = 1'b0;
    checks++;
    if ({g, gr} !== {16'h0000, 16'h3333} || nur != 1 || nfs != 0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL late_frame_left: bits=%h/%h ur=%0d fs=%0d ready=%b, want 0000/3333 1 0 0",
               g, gr, nur, nfs, ready);
    end
    chan(1'b1, 32, g, gr, f0, pz, nfs, fs0, nur, sk);
    chan(1'b0, 32, g, gr, f0, pz, nfs, fs0, nur, sk);
    checks++;
    if ({g, gr} !== {16'h5555, 16'h5555} || nfs != 1) begin
      errors++;
      $display("FAIL late_frame_played: bits=%h/%h fs=%0d, want 5555/5555 1", g, gr, nfs);
    end
    chan(1'b1, 32, g, gr, f0, pz, nfs, fs0, nur, sk);
    checks++;
    if (g !== 16'h6666 || cnt !== 16'd2) begin
      errors++;
      $display("FAIL late_frame_right: bits=%h cnt=%0d, want 6666 2", g, cnt);
    end
  endtask

  task automatic test_early_edge;
    offer(16'hABCD, 16'h1234);
    chan(1'b0, 10, g, gr, f0, pz, nfs, fs0, nur, sk);
    checks++;
    if (f0 !== 1'b0 || g !== (16'hABCD >> 7) || nfs != 1) begin
      errors++;
      $display("FAIL early_left: delay=%b bits=%h fs=%0d, want 0 %h 1", f0, g, nfs, 16'hABCD >> 7);
    end
    chan(1'b1, 10, g, gr, f0, pz, nfs, fs0, nur, sk);
    checks++;
    if (f0 !== 1'b0 || g !== (16'h1234 >> 7)) begin
      errors++;
      $display("FAIL early_right: delay=%b bits=%h, want 0 %h", f0, g, 16'h1234 >> 7);
    end
    chan(1'b0, 10, g, gr, f0, pz, nfs, fs0, nur, sk);
    checks++;
    if ({g, gr} !== {16'h0000, 16'hABCD >> 7} || nur != 1) begin
      errors++;
      $display("FAIL early_underrun: bits=%h/%h ur=%0d, want 0000/%h 1", g, gr, nur,
               16'hABCD >> 7);
    end
    chan(1'b1, 32, g, gr, f0, pz, nfs, fs0, nur, sk);
    checks++;
    if ({g, gr, pz} !== {16'h0000, 16'h1234, 1'b0} || cnt !== 16'd3) begin
      errors++;
      $display("FAIL early_recover: bits=%h/%h pad=%b cnt=%0d, want 0000/1234 0 3",
               g, gr, pz, cnt);
    end
  endtask

  task automatic test_reset_mid_frame;
    offer(16'hFF00, 16'h0000);
    chan(1'b0, 9, g, gr, f0, pz, nfs, fs0, nur, sk);
    checks++;
    if (g !== 16'h00FF || dacdat !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_bits: bits=%h dacdat=%b, want 00ff 1", g, dacdat);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dacdat !== 1'b0 || cnt !== 16'd0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: dacdat=%b cnt=%0d ready=%b, want 0 0 1", dacdat, cnt, ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step;
    offer(16'h1357, 16'h2468);
    chan(1'b1, 32, g, gr, f0, pz, nfs, fs0, nur, sk);
    checks++;
    if ({f0, g, pz} !== 18'd0 || nfs != 0 || nur != 0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL first_right_ignored: bits=%h fs=%0d ur=%0d ready=%b, want 0000 0 0 0",
               g, nfs, nur, ready);
    end
    chan(1'b0, 32, g, gr, f0, pz, nfs, fs0, nur, sk);
    checks++;
    if (g !== 16'h1357 || nfs != 1) begin
      errors++;
      $display("FAIL resume_left: bits=%h fs=%0d, want 1357 1", g, nfs);
    end
    chan(1'b1, 32, g, gr, f0, pz, nfs, fs0, nur, sk);
    checks++;
    if (g !== 16'h2468) begin
      errors++;
      $display("FAIL resume_right: bits=%h, want 2468", g);
    end
  endtask

  task automatic test_saturate;
    logic [15:0] exp;
    // Preload the counter near the top instead of spending 65k LRCK periods.
    force dut.underrun_cnt_q = 16'hFFFD;
    step;
    release dut.underrun_cnt_q;
    step;
    checks++;
    if (cnt !== 16'hFFFD) begin
      errors++;
      $display("FAIL sat_preload: cnt=%h, want fffd", cnt);
    end
    for (int k = 0; k < 3; k++) begin
      chan(1'b0, 4, g, gr, f0, pz, nfs, fs0, nur, sk);
      chan(1'b1, 4, g, gr, f0, pz, nfs, fs0, nur, sk);
      exp = (k == 0) ? 16'hFFFE : 16'hFFFF;
      checks++;
      if (cnt !== exp) begin
        errors++;
        $display("FAIL sat_count_%0d: cnt=%h, want %h", k, cnt, exp);
      end
    end
  endtask

  task automatic test_disable;
    offer(16'hFFFF, 16'hFFFF);
    chan(1'b0, 6, g, gr, f0, pz, nfs, fs0, nur, sk);
    checks++;
    if (g !== 16'h001F || nur != 0) begin
      errors++;
      $display("FAIL dis_pre_bits: bits=%h ur=%0d, want 001f 0", g, nur);
    end
    offer(16'h0001, 16'h0001);
    en = 1'b0;
    step;
    checks++;
    if (dacdat !== 1'b0 || ready !== 1'b0 || cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL disable: dacdat=%b ready=%b cnt=%h, want 0 0 ffff", dacdat, ready, cnt);
    end
    en = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL disable_flush: ready=%b, want 1", ready);
    end
    step;
    checks++;
    if (dacdat !== 1'b0 || cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL reenable_idle: dacdat=%b cnt=%h, want 0 ffff", dacdat, cnt);
    end
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_underrun;
    test_back_to_back;
    test_early_edge;
    test_reset_mid_frame;
    test_saturate;
    test_disable;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
